// File: rtl/register_writeback_arbiter.sv
// Writeback arbiter: ALU and LSU FIFOs merged into one masked register write port.
// Define WB_LSU_PRIORITY_EN for fixed LSU priority instead of round-robin.
module wb_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [CW-1:0] cnt_q;

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + PW'(1);
            if (pop_i)  rd_q <= rd_q + PW'(1);
            cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_q];
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
endmodule

module register_writeback_arbiter #(
    parameter int LANES      = 16,
    parameter int DATA_W     = 64,
    parameter int ADDR_W     = 6,
    parameter int WARP_W     = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [WARP_W-1:0]       alu_warp,
    input  logic [ADDR_W-1:0]       alu_addr,
    input  logic [LANES-1:0]        alu_mask,
    input  logic [LANES*DATA_W-1:0] alu_data,
    input  logic                    lsu_valid,
    output logic                    lsu_ready,
    input  logic [WARP_W-1:0]       lsu_warp,
    input  logic [ADDR_W-1:0]       lsu_addr,
    input  logic [LANES-1:0]        lsu_mask,
    input  logic [LANES*DATA_W-1:0] lsu_data,
    input  logic                    wb_stall,
    output logic [LANES-1:0]        write_en,
    output logic [ADDR_W-1:0]       waddr,
    output logic [WARP_W-1:0]       wb_warp,
    output logic [LANES*DATA_W-1:0] wdata
);
    localparam int EW = WARP_W + ADDR_W + LANES + LANES * DATA_W;

    logic          alu_full, alu_empty, lsu_full, lsu_empty;
    logic          alu_push, lsu_push;
    logic          gnt_alu, gnt_lsu;
    logic [EW-1:0] alu_head, lsu_head, head;

    logic [LANES-1:0]        write_en_q;
    logic [ADDR_W-1:0]       waddr_q;
    logic [WARP_W-1:0]       wb_warp_q;
    logic [LANES*DATA_W-1:0] wdata_q;

    assign alu_ready = !rst && !alu_full;
    assign lsu_ready = !rst && !lsu_full;
    assign alu_push  = alu_valid && alu_ready;
    assign lsu_push  = lsu_valid && lsu_ready;

    wb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk_i  (clk),
        .rst_i  (rst),
        .push_i (alu_push),
        .din_i  ({alu_warp, alu_addr, alu_mask, alu_data}),
        .pop_i  (gnt_alu),
        .dout_o (alu_head),
        .full_o (alu_full),
        .empty_o(alu_empty)
    );

    wb_fifo #(.W(EW), .DEPTH(FIFO_DEPTH)) u_lsu_fifo (
        .clk_i  (clk),
        .rst_i  (rst),
        .push_i (lsu_push),
        .din_i  ({lsu_warp, lsu_addr, lsu_mask, lsu_data}),
        .pop_i  (gnt_lsu),
        .dout_o (lsu_head),
        .full_o (lsu_full),
        .empty_o(lsu_empty)
    );

`ifndef WB_LSU_PRIORITY_EN
    logic ptr_q;
    logic ptr_d;

    // Pointer names the source that wins the next contended cycle (0 = ALU).
    always_ff @(posedge clk) begin
        if (rst) ptr_q <= 1'b0;
        else     ptr_q <= ptr_d;
    end

    always_comb begin
        ptr_d = ptr_q;
        if (gnt_alu)      ptr_d = 1'b1;
        else if (gnt_lsu) ptr_d = 1'b0;
    end
`endif

    always_comb begin
        gnt_alu = 1'b0;
        gnt_lsu = 1'b0;
        if (!wb_stall) begin
            if (!alu_empty && !lsu_empty) begin
`ifdef WB_LSU_PRIORITY_EN
                gnt_lsu = 1'b1;
`else
                gnt_lsu = ptr_q;
                gnt_alu = !ptr_q;
`endif
            end else begin
                gnt_alu = !alu_empty;
                gnt_lsu = !lsu_empty;
            end
        end
    end

    assign head = gnt_lsu ? lsu_head : alu_head;

    always_ff @(posedge clk) begin
        if (rst) begin
            write_en_q <= '0;
            waddr_q    <= '0;
            wb_warp_q  <= '0;
            wdata_q    <= '0;
        end else if (gnt_alu || gnt_lsu) begin
            {wb_warp_q, waddr_q, write_en_q, wdata_q} <= head;
        end else begin
            write_en_q <= '0;
        end
    end

    assign write_en = write_en_q;
    assign waddr    = waddr_q;
    assign wb_warp  = wb_warp_q;
    assign wdata    = wdata_q;
endmodule
